// File: rtl/core_pkg.sv
// Shared definitions for the fetch front end: sequencer states and
// instruction-alignment helpers used by the next-PC logic.
package core_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

  // Low address bits that violate 4-byte instruction alignment
  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return |(addr_lsbs & INSTR_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux (trap > JALR > branch > sequential)
// with misaligned-target detection and redirect to the trap vector.
module pc_next_sel
  import core_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc_plus_4,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jalr_taken,
  input  logic [PC_WIDTH-1:0] jalr_target,
  input  logic                trap_req,
  input  logic [PC_WIDTH-1:0] trap_vector,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                misaligned,
  output logic [PC_WIDTH-1:0] fault_target
);

  logic [PC_WIDTH-1:0] trap_pc_s;
  logic [PC_WIDTH-1:0] jalr_pc_s;

  assign trap_pc_s = trap_vector & {{(PC_WIDTH-2){1'b1}}, 2'b00};
  assign jalr_pc_s = jalr_target & {{(PC_WIDTH-1){1'b1}}, 1'b0};

  // Select the redirect source; a misaligned JALR/branch target diverts to the trap vector
  always_comb begin
    next_pc      = pc_plus_4;
    misaligned   = 1'b0;
    fault_target = {PC_WIDTH{1'b0}};
    if (trap_req) begin
      next_pc = trap_pc_s;
    end else if (jalr_taken) begin
      fault_target = jalr_target;
      if (is_misaligned(jalr_pc_s[1:0])) begin
        misaligned = 1'b1;
        next_pc    = trap_pc_s;
      end else begin
        next_pc = jalr_pc_s;
      end
    end else if (branch_taken) begin
      fault_target = branch_target;
      if (is_misaligned(branch_target[1:0])) begin
        misaligned = 1'b1;
        next_pc    = trap_pc_s;
      end else begin
        next_pc = branch_target;
      end
    end else begin
      next_pc = pc_plus_4;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch sequencer: owns the PC, the
// BOOT/FETCH/HOLD handshake FSM and the misaligned-target fault report.
module pc_fetch_ctrl
  import core_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] PC,
  input  logic [PC_WIDTH-1:0] PC_Plus_4,
  input  logic                Branch_Taken,
  input  logic [PC_WIDTH-1:0] Branch_Target,
  input  logic                Jalr_Taken,
  input  logic [PC_WIDTH-1:0] Jalr_Target,
  input  logic                Trap_Req,
  input  logic [PC_WIDTH-1:0] Trap_Vector,
  input  logic                Stall,
  output logic                IMem_Req,
  output logic [PC_WIDTH-1:0] IMem_Addr,
  input  logic                IMem_Ready,
  output logic                Instr_Valid,
  output logic                Misaligned_Fault,
  output logic [PC_WIDTH-1:0] Fault_PC
);

  fetch_state_e        state_r;
  logic [PC_WIDTH-1:0] pc_r;
  logic                fault_r;
  logic [PC_WIDTH-1:0] fault_pc_r;

  logic [PC_WIDTH-1:0] next_pc_s;
  logic                misaligned_s;
  logic [PC_WIDTH-1:0] fault_target_s;
  logic                pc_upd_s;

  pc_next_sel #(
    .PC_WIDTH(PC_WIDTH)
  ) u_next_sel (
    .pc_plus_4    (PC_Plus_4),
    .branch_taken (Branch_Taken),
    .branch_target(Branch_Target),
    .jalr_taken   (Jalr_Taken),
    .jalr_target  (Jalr_Target),
    .trap_req     (Trap_Req),
    .trap_vector  (Trap_Vector),
    .next_pc      (next_pc_s),
    .misaligned   (misaligned_s),
    .fault_target (fault_target_s)
  );

  // PC-update cycles: accepted fetch, stall release, or a trap anywhere past BOOT
  always_comb begin
    pc_upd_s = 1'b0;
    case (state_r)
      FETCH:   pc_upd_s = Trap_Req | (IMem_Ready & ~Stall);
      HOLD:    pc_upd_s = Trap_Req | ~Stall;
      default: pc_upd_s = 1'b0;
    endcase
  end

  // Sequencer FSM with PC register and fault reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= BOOT;
      pc_r       <= RESET_VECTOR;
      fault_r    <= 1'b0;
      fault_pc_r <= {PC_WIDTH{1'b0}};
    end else begin
      if (pc_upd_s) begin
        pc_r <= next_pc_s;
      end else begin
        pc_r <= pc_r;
      end

      if (pc_upd_s && misaligned_s) begin
        fault_r    <= 1'b1;
        fault_pc_r <= fault_target_s;
      end else begin
        fault_r <= 1'b0;
      end

      case (state_r)
        BOOT: state_r <= FETCH;
        FETCH: begin
          if (pc_upd_s) begin
            state_r <= FETCH;
          end else if (IMem_Ready) begin
            state_r <= HOLD;
          end else begin
            state_r <= FETCH;
          end
        end
        HOLD: begin
          if (pc_upd_s) begin
            state_r <= FETCH;
          end else begin
            state_r <= HOLD;
          end
        end
        default: state_r <= BOOT;
      endcase
    end
  end

  // Request and valid decode straight from the state so reset drops them at once
  assign IMem_Req         = (state_r == FETCH);
  assign Instr_Valid      = (state_r == FETCH) & IMem_Ready;
  assign IMem_Addr        = pc_r;
  assign PC               = pc_r;
  assign Misaligned_Fault = fault_r;
  assign Fault_PC         = fault_pc_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl: boot, wait states,
// redirect priority, stall/hold, misalignment, wrap and async reset.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] PC;
  logic [31:0] PC_Plus_4;
  logic        Branch_Taken = 1'b0;
  logic [31:0] Branch_Target = 32'h0;
  logic        Jalr_Taken = 1'b0;
  logic [31:0] Jalr_Target = 32'h0;
  logic        Trap_Req = 1'b0;
  logic [31:0] Trap_Vector = 32'h0;
  logic        Stall = 1'b0;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ready = 1'b0;
  logic        Instr_Valid;
  logic        Misaligned_Fault;
  logic [31:0] Fault_PC;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Bench-side model of the external PC incrementer
  assign PC_Plus_4 = PC + 32'd4;

  pc_fetch_ctrl #(.PC_WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .PC_Plus_4(PC_Plus_4),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .Jalr_Taken(Jalr_Taken), .Jalr_Target(Jalr_Target),
    .Trap_Req(Trap_Req), .Trap_Vector(Trap_Vector), .Stall(Stall),
    .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Ready(IMem_Ready),
    .Instr_Valid(Instr_Valid), .Misaligned_Fault(Misaligned_Fault), .Fault_PC(Fault_PC)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    Branch_Taken = 1'b0;
    Jalr_Taken   = 1'b0;
    Trap_Req     = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    IMem_Ready = 1'b1;
    #1;
    tests++; if (PC !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h exp %h", PC, 32'h0); end
    tests++; if (IMem_Req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b exp 0", IMem_Req); end
    tests++; if (Instr_Valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b exp 0", Instr_Valid); end
    tests++; if (Misaligned_Fault !== 1'b0 || Fault_PC !== 32'h0) begin fails++; $display("FAIL rst_fault: got %b/%h exp 0/0", Misaligned_Fault, Fault_PC); end
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if (IMem_Req !== 1'b0) begin fails++; $display("FAIL boot_idle_req: got %b exp 0", IMem_Req); end
    tick();
    tests++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0) begin fails++; $display("FAIL boot_first_fetch: got %b/%h exp 1/0", IMem_Req, IMem_Addr); end
    tests++; if (Instr_Valid !== 1'b1) begin fails++; $display("FAIL boot_valid0: got %b exp 1", Instr_Valid); end
    tick();
    tests++; if (PC !== 32'h4 || Instr_Valid !== 1'b1) begin fails++; $display("FAIL boot_pc4: got %h/%b exp 4/1", PC, Instr_Valid); end
    tick();
    tests++; if (PC !== 32'h8 || Instr_Valid !== 1'b1) begin fails++; $display("FAIL boot_pc8: got %h/%b exp 8/1", PC, Instr_Valid); end
  endtask

  task automatic test_wait_states();
    tick(); tick();
    tests++; if (PC !== 32'h10) begin fails++; $display("FAIL ws_reach: got %h exp 10", PC); end
    IMem_Ready = 1'b0;
    Branch_Taken = 1'b1; Branch_Target = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (PC !== 32'h10 || Instr_Valid !== 1'b0 || IMem_Req !== 1'b1) begin
        fails++; $display("FAIL ws_hold%0d: got pc=%h v=%b r=%b exp 10/0/1", i, PC, Instr_Valid, IMem_Req);
      end
      tick();
    end
    Branch_Taken = 1'b0;
    IMem_Ready = 1'b1;
    #1;
    tests++; if (Instr_Valid !== 1'b1 || PC !== 32'h10) begin fails++; $display("FAIL ws_ready: got %b/%h exp 1/10", Instr_Valid, PC); end
    tick();
    tests++; if (PC !== 32'h14) begin fails++; $display("FAIL ws_adv: got %h exp 14", PC); end
  endtask

  task automatic test_priority();
    tick(); tick(); tick();
    tests++; if (PC !== 32'h20) begin fails++; $display("FAIL prio_reach: got %h exp 20", PC); end
    Branch_Taken = 1'b1; Branch_Target = 32'h0000_0100;
    Jalr_Taken = 1'b1; Jalr_Target = 32'h0000_0205;
    tick();
    tests++; if (PC !== 32'h204 || Misaligned_Fault !== 1'b0) begin fails++; $display("FAIL prio_jalr: got %h/%b exp 204/0", PC, Misaligned_Fault); end
    Trap_Req = 1'b1; Trap_Vector = 32'h0000_0803;
    tick();
    tests++; if (PC !== 32'h800) begin fails++; $display("FAIL prio_trap: got %h exp 800", PC); end
    clear_redirects();
    tick();
    tests++; if (PC !== 32'h804) begin fails++; $display("FAIL prio_seq: got %h exp 804", PC); end
  endtask

  task automatic test_stall();
    Branch_Taken = 1'b1; Branch_Target = 32'h0000_0040;
    tick();
    clear_redirects();
    Stall = 1'b1;
    #1;
    tests++; if (PC !== 32'h40 || IMem_Req !== 1'b1 || Instr_Valid !== 1'b1) begin fails++; $display("FAIL stall_pre: got %h/%b/%b exp 40/1/1", PC, IMem_Req, Instr_Valid); end
    tick();
    tests++; if (PC !== 32'h40 || IMem_Req !== 1'b0 || Instr_Valid !== 1'b0) begin fails++; $display("FAIL stall_hold1: got %h/%b/%b exp 40/0/0", PC, IMem_Req, Instr_Valid); end
    tick();
    tests++; if (PC !== 32'h40 || IMem_Req !== 1'b0) begin fails++; $display("FAIL stall_hold2: got %h/%b exp 40/0", PC, IMem_Req); end
    Stall = 1'b0;
    Branch_Taken = 1'b1; Branch_Target = 32'h0000_0080;
    tick();
    clear_redirects();
    tests++; if (PC !== 32'h80 || IMem_Req !== 1'b1) begin fails++; $display("FAIL stall_resume: got %h/%b exp 80/1", PC, IMem_Req); end
    Stall = 1'b1;
    tick();
    tests++; if (IMem_Req !== 1'b0 || PC !== 32'h80) begin fails++; $display("FAIL stall_hold3: got %b/%h exp 0/80", IMem_Req, PC); end
    Trap_Req = 1'b1; Trap_Vector = 32'h0000_0300;
    tick();
    clear_redirects();
    Stall = 1'b0;
    #1;
    tests++; if (PC !== 32'h300 || IMem_Req !== 1'b1) begin fails++; $display("FAIL stall_trap: got %h/%b exp 300/1", PC, IMem_Req); end
  endtask

  task automatic test_misaligned();
    Branch_Taken = 1'b1; Branch_Target = 32'h0000_0102; Trap_Vector = 32'h0000_0300;
    #1;
    tests++; if (Misaligned_Fault !== 1'b0) begin fails++; $display("FAIL mis_pre: got %b exp 0", Misaligned_Fault); end
    tick();
    clear_redirects();
    tests++; if (PC !== 32'h300 || Misaligned_Fault !== 1'b1 || Fault_PC !== 32'h102) begin
      fails++; $display("FAIL mis_branch: got %h/%b/%h exp 300/1/102", PC, Misaligned_Fault, Fault_PC);
    end
    tick();
    tests++; if (Misaligned_Fault !== 1'b0 || Fault_PC !== 32'h102 || PC !== 32'h304) begin
      fails++; $display("FAIL mis_pulse_end: got %b/%h/%h exp 0/102/304", Misaligned_Fault, Fault_PC, PC);
    end
    Branch_Taken = 1'b1; Branch_Target = 32'h0000_0102;
    Trap_Req = 1'b1; Trap_Vector = 32'h0000_0500;
    tick();
    clear_redirects();
    tests++; if (PC !== 32'h500 || Misaligned_Fault !== 1'b0 || Fault_PC !== 32'h102) begin
      fails++; $display("FAIL mis_trap_wins: got %h/%b/%h exp 500/0/102", PC, Misaligned_Fault, Fault_PC);
    end
    Jalr_Taken = 1'b1; Jalr_Target = 32'h0000_0207; Trap_Vector = 32'h0000_0300;
    tick();
    clear_redirects();
    tests++; if (PC !== 32'h300 || Misaligned_Fault !== 1'b1 || Fault_PC !== 32'h207) begin
      fails++; $display("FAIL mis_jalr: got %h/%b/%h exp 300/1/207", PC, Misaligned_Fault, Fault_PC);
    end
    Jalr_Taken = 1'b1; Jalr_Target = 32'h0000_0211;
    tick();
    clear_redirects();
    tests++; if (PC !== 32'h210 || Misaligned_Fault !== 1'b0) begin fails++; $display("FAIL jalr_bit0: got %h/%b exp 210/0", PC, Misaligned_Fault); end
  endtask

  task automatic test_wrap_and_reset();
    Branch_Taken = 1'b1; Branch_Target = 32'hFFFF_FFFC;
    tick();
    clear_redirects();
    tests++; if (PC !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_reach: got %h exp fffffffc", PC); end
    tick();
    tests++; if (PC !== 32'h0 || Misaligned_Fault !== 1'b0) begin fails++; $display("FAIL wrap: got %h/%b exp 0/0", PC, Misaligned_Fault); end
    tick();
    tests++; if (PC !== 32'h4 || IMem_Req !== 1'b1) begin fails++; $display("FAIL wrap_next: got %h/%b exp 4/1", PC, IMem_Req); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (PC !== 32'h0 || IMem_Req !== 1'b0 || Instr_Valid !== 1'b0) begin
      fails++; $display("FAIL async_rst: got %h/%b/%b exp 0/0/0", PC, IMem_Req, Instr_Valid);
    end
    tick();
    tests++; if (PC !== 32'h0 || Instr_Valid !== 1'b0) begin fails++; $display("FAIL rst_held: got %h/%b exp 0/0", PC, Instr_Valid); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h0) begin fails++; $display("FAIL reboot: got %b/%h exp 1/0", IMem_Req, IMem_Addr); end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_priority();
    test_stall();
    test_misaligned();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter register and next-PC sequencer for the RV32IM core.
- Consumes PC_Plus_4 from the PC incrementer and feeds PC back to it.
- Selects the next PC from trap, JALR, branch or sequential sources.
- Drives the instruction-memory fetch request/ready handshake.
- Detects misaligned control-flow targets and redirects them to the trap vector.

Parameters:
- PC_WIDTH, 32, width of PC and all address/target ports.
- RESET_VECTOR, 32'h0000_0000, PC value on reset. Bits [1:0] must be 0.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- PC  out  PC_WIDTH  current PC, registered.
- PC_Plus_4  in  PC_WIDTH  sequential next address from the incrementer.
- Branch_Taken  in  1  conditional branch resolved taken.
- Branch_Target  in  PC_WIDTH  branch/JAL target.
- Jalr_Taken  in  1  JALR executing.
- Jalr_Target  in  PC_WIDTH  raw rs1+imm. Bit 0 is cleared internally.
- Trap_Req  in  1  exception/interrupt redirect request.
- Trap_Vector  in  PC_WIDTH  trap handler base. Bits [1:0] are forced to 0.
- Stall  in  1  hold PC (hazard/multi-cycle M-unit).
- IMem_Req  out  1  fetch request.
- IMem_Addr  out  PC_WIDTH  fetch address; always equals PC.
- IMem_Ready  in  1  instruction returned this cycle.
- Instr_Valid  out  1  fetched instruction valid this cycle.
- Misaligned_Fault  out  1  one-cycle pulse on a misaligned target.
- Fault_PC  out  PC_WIDTH  offending target, registered.

Behaviour:
Reset:
- rst_n=0 immediately forces: PC=RESET_VECTOR, state=BOOT, Misaligned_Fault=0, Fault_PC=0.
- This is combinationally visible: IMem_Req=0 and Instr_Valid=0 during reset.
- A reset during a pending fetch aborts it; no Instr_Valid is produced.

FSM states: BOOT, FETCH, HOLD.
- BOOT: IMem_Req=0. Go to FETCH next cycle unconditionally. Exactly one idle cycle after reset release.
- FETCH: IMem_Req=1, IMem_Addr=PC, Instr_Valid = IMem_Ready (combinational).
  - IMem_Ready=0: hold PC, stay in FETCH.
  - IMem_Ready=1 and Stall=0: PC <= next_pc, stay in FETCH.
  - IMem_Ready=1 and Stall=1: hold PC, go to HOLD.
- HOLD: IMem_Req=0, Instr_Valid=0.
  - Stall=1: stay in HOLD.
  - Stall=0: PC <= next_pc, go to FETCH.

next_pc priority (only one source applies):
1. Trap_Req -> {Trap_Vector[PC_WIDTH-1:2], 2'b00}
2. Jalr_Taken -> {Jalr_Target[PC_WIDTH-1:1], 1'b0}
3. Branch_Taken -> Branch_Target
4. otherwise -> PC_Plus_4

Trap override:
- Trap_Req is honoured in any non-BOOT state, regardless of Stall or IMem_Ready.
- Action: PC <= trap vector, state <= FETCH.
- Any pending fetch is abandoned. IMem_Req stays high with the new address; the memory has no outstanding-transaction state.

Misalignment:
- Applies when the selected JALR or branch target has bit 1 set (bit 0 is covered too).
- PC <= trap vector; Misaligned_Fault=1 for exactly one cycle; Fault_PC <= the raw selected target.
- Fault_PC holds its value until the next fault.
- A trap that arrives in the same cycle takes precedence; no fault is flagged.

Wrap-around:
- PC=32'hFFFF_FFFC with PC_Plus_4=0 gives PC=0.
- No fault; this is normal modulo-2^PC_WIDTH behaviour.

Redirect sampling:
- Redirect inputs are ignored except on PC-update cycles.
- Trap_Req is the only exception.

Decomposition:
- Shared package core_pkg:
  - FSM state typedef: BOOT=2'd0, FETCH=2'd1, HOLD=2'd2.
  - Constant INSTR_ALIGN_MASK=2'b11.
- Optional sub-module pc_next_sel: the combinational priority mux plus misalignment detect.
- The FSM and PC register stay in pc_fetch_ctrl.

Test Plan:
1. Reset and boot: release rst_n.
   -> One cycle with IMem_Req=0.
   -> Then IMem_Req=1 with IMem_Addr=0x0.
   -> With IMem_Ready held 1, PC goes 0x0, 0x4, 0x8, and Instr_Valid is 1 each cycle.
2. Wait states: PC=0x10, IMem_Ready low for 3 cycles.
   -> PC stays 0x10, Instr_Valid=0.
   -> On ready: Instr_Valid=1, then PC=0x14.
3. Priority: at PC=0x20 with ready, assert Branch_Taken (target 0x100) and Jalr_Taken (target 0x205) together.
   -> PC=0x204.
   -> Repeat with Trap_Req=1 and Trap_Vector=0x803: PC=0x800.
4. Stall: at PC=0x40, ready=1 and Stall=1 for 2 cycles.
   -> HOLD entered, IMem_Req=0, PC=0x40.
   -> Drop Stall with Branch_Taken and target 0x80: PC=0x80, FETCH resumes.
5. Misaligned branch: Branch_Target=0x102, Trap_Vector=0x300.
   -> PC=0x300, one-cycle Misaligned_Fault, Fault_PC=0x102.
   -> Trap_Req in the same cycle: no fault pulse.
6. Wrap and async reset: PC=0xFFFF_FFFC with PC_Plus_4=0.
   -> PC=0x0 next cycle.
   -> Assert rst_n=0 mid-fetch: PC=RESET_VECTOR and IMem_Req=0 before the next clock edge.
